// File: rtl/esn_mse_monitor_if.sv
// Handshake/bus bundle between the ESN readout, the MSE monitor and its training-control consumer.
// master = driver of samples/start/ready, slave = the monitor itself.
interface esn_mse_monitor_if #(
    parameter int DATA_W = 32
);
    logic                     start;
    logic                     in_valid;
    logic signed [DATA_W-1:0] est;
    logic signed [DATA_W-1:0] target;
    logic                     mse_valid;
    logic                     mse_ready;
    logic [31:0]              mse;
    logic                     sat;
    logic                     busy;
    logic [2:0]               state_dbg;

    modport master (
        output start, in_valid, est, target, mse_ready,
        input  mse_valid, mse, sat, busy, state_dbg
    );

    modport slave (
        input  start, in_valid, est, target, mse_ready,
        output mse_valid, mse, sat, busy, state_dbg
    );
endinterface

// File: rtl/esn_mse_monitor.sv
// Windowed mean-squared-error monitor for the ESN readout: discards a washout run,
// accumulates squared Q16.16 error over 2^LOG2_WIN samples and offers the result on valid/ready.
module esn_mse_monitor #(
    parameter int DATA_W   = 32,
    parameter int FRAC_W   = 16,
    parameter int WASHOUT  = 16,
    parameter int LOG2_WIN = 6,
    parameter int ACC_W    = 48
) (
    input  logic             clk,
    input  logic             rst,
    esn_mse_monitor_if.slave bus
);
    // Result handshake: mse_valid is high only in HOLD with mse/sat stable; the result
    // transfers on the rising edge where mse_valid and mse_ready are both high, and
    // mse_valid drops on that same edge. mse_ready while mse_valid is low is ignored.

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WASH  = 3'd1,
        ST_ACCUM = 3'd2,
        ST_DRAIN = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    localparam int WASH_CW = (WASHOUT > 1) ? $clog2(WASHOUT) : 1;
    localparam logic [WASH_CW-1:0]  WASH_LAST = WASH_CW'((WASHOUT > 0) ? WASHOUT - 1 : 0);
    localparam logic [LOG2_WIN-1:0] WIN_LAST  = {LOG2_WIN{1'b1}};
    localparam logic [1:0]          DRAIN_LAST = 2'd2;
    localparam int                  PW = 2 * DATA_W;
    localparam logic [ACC_W-1:0]    ACC_MAX = {ACC_W{1'b1}};
    localparam logic [DATA_W-1:0]   ERR_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0]   ERR_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    state_t state, state_nxt;

    logic [WASH_CW-1:0]  wash_cnt;
    logic [LOG2_WIN-1:0] win_cnt;
    logic [1:0]          drain_cnt;

    logic                     v0, v1;
    logic signed [DATA_W-1:0] err_q;
    logic [ACC_W-1:0]         sq_q;
    logic [ACC_W-1:0]         acc;
    logic [31:0]              mse_q;
    logic                     sat_q;

    logic start_acc, accept_win, drain_done;
    assign start_acc  = (state == ST_IDLE) && bus.start;
    assign accept_win = (state == ST_ACCUM) && bus.in_valid;
    assign drain_done = (state == ST_DRAIN) && (drain_cnt == DRAIN_LAST);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (bus.start) state_nxt = (WASHOUT == 0) ? ST_ACCUM : ST_WASH;
            ST_WASH:  if (bus.in_valid && wash_cnt == WASH_LAST) state_nxt = ST_ACCUM;
            ST_ACCUM: if (bus.in_valid && win_cnt == WIN_LAST) state_nxt = ST_DRAIN;
            // DRAIN lasts until the last square has landed in acc and mse is registered.
            ST_DRAIN: if (drain_cnt == DRAIN_LAST) state_nxt = ST_HOLD;
            ST_HOLD:  if (bus.mse_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.busy      = (state != ST_IDLE);
        bus.mse_valid = (state == ST_HOLD);
        bus.state_dbg = state;
        bus.mse       = mse_q;
        bus.sat       = sat_q;
    end

    // ---------------- counters ----------------
    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            wash_cnt  <= '0;
            win_cnt   <= '0;
            drain_cnt <= '0;
        end else begin
            if (state == ST_WASH && bus.in_valid) wash_cnt <= wash_cnt + 1'b1;
            if (accept_win)                      win_cnt  <= win_cnt + 1'b1;
            if (state == ST_DRAIN)               drain_cnt <= drain_cnt + 1'b1;
        end
    end

    // ---------------- E0: saturated error ----------------
    logic [DATA_W:0]   diff;
    logic              err_ovf;
    logic [DATA_W-1:0] err_d;
    assign diff = {bus.target[DATA_W-1], bus.target} - {bus.est[DATA_W-1], bus.est};

    always_comb begin
        err_ovf = diff[DATA_W] ^ diff[DATA_W-1];
        err_d   = diff[DATA_W-1:0];
        if (err_ovf) err_d = diff[DATA_W] ? ERR_MIN : ERR_MAX;
    end

    // ---------------- E1: square, rescaled to Q16.16 ----------------
    logic signed [PW-1:0] prod;
    logic [PW-1:0]        prod_shr;
    assign prod     = PW'(err_q) * PW'(err_q);
    assign prod_shr = $unsigned(prod) >> FRAC_W;

    // ---------------- E2 / E3: accumulate and scale ----------------
    logic [ACC_W:0]   acc_sum;
    logic [ACC_W-1:0] acc_shr;
    logic             mse_ovf;
    assign acc_sum = {1'b0, acc} + {1'b0, sq_q};
    assign acc_shr = acc >> LOG2_WIN;
    assign mse_ovf = |acc_shr[ACC_W-1:32];

    always_ff @(posedge clk) begin
        if (rst) begin
            v0    <= 1'b0;
            v1    <= 1'b0;
            err_q <= '0;
            sq_q  <= '0;
            acc   <= '0;
            mse_q <= '0;
            sat_q <= 1'b0;
        end else if (start_acc) begin
            v0    <= 1'b0;
            v1    <= 1'b0;
            err_q <= '0;
            sq_q  <= '0;
            acc   <= '0;
            mse_q <= '0;
            sat_q <= 1'b0;
        end else begin
            v0 <= accept_win;
            v1 <= v0;
            if (accept_win) begin
                err_q <= err_d;
                if (err_ovf) sat_q <= 1'b1;
            end
            if (v0) sq_q <= prod_shr[ACC_W-1:0];
            if (v1) begin
                if (acc_sum[ACC_W]) begin
                    acc   <= ACC_MAX;
                    sat_q <= 1'b1;
                end else begin
                    acc <= acc_sum[ACC_W-1:0];
                end
            end
            if (drain_done) begin
                mse_q <= mse_ovf ? 32'hFFFF_FFFF : acc_shr[31:0];
                if (mse_ovf) sat_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_esn_mse_monitor.sv
// Randomized bench for esn_mse_monitor: each measurement is predicted from the accepted
// window samples with plain integer arithmetic and compared at the result handshake.
module tb_esn_mse_monitor;
    localparam int WASHOUT  = 16;
    localparam int LOG2_WIN = 6;
    localparam int WIN      = 1 << LOG2_WIN;
    localparam longint unsigned ACC_MAX = (64'd1 << 48) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    esn_mse_monitor_if #(.DATA_W(32)) bus ();

    esn_mse_monitor #(
        .DATA_W(32), .FRAC_W(16), .WASHOUT(WASHOUT), .LOG2_WIN(LOG2_WIN), .ACC_W(48)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];
    logic        exp_sat_q[$];
    longint      win_err[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: clamp each window error, square in Q16.16, saturate the sum, divide by window.
    task automatic model_push();
        longint           e;
        longint unsigned  sq;
        longint unsigned  sum;
        longint unsigned  m;
        logic             s;
        sum = 0;
        s   = 1'b0;
        foreach (win_err[i]) begin
            e = win_err[i];
            if (e > 64'sd2147483647) begin e = 64'sd2147483647; s = 1'b1; end
            else if (e < -64'sd2147483648) begin e = -64'sd2147483648; s = 1'b1; end
            sq  = longint'(e * e) >> 16;
            sum = sum + sq;
        end
        if (sum > ACC_MAX) begin sum = ACC_MAX; s = 1'b1; end
        m = sum / WIN;
        if (m > 64'hFFFF_FFFF) begin m = 64'hFFFF_FFFF; s = 1'b1; end
        exp_q.push_back(m[31:0]);
        exp_sat_q.push_back(s);
    endtask

    task automatic gen(input int mode, input int idx, output logic [31:0] e, output logic [31:0] t);
        logic [31:0] r;
        r = $urandom_range(0, 32'h01FF_FFFF) - 32'h0100_0000;
        case (mode)
            0: begin e = 32'h0001_0000; t = 32'h0001_0000; end
            1: begin e = 32'h0001_0000; t = 32'h0002_0000; end
            2: begin e = r; t = (idx < WASHOUT) ? r + 32'h0064_0000 : r; end
            3: begin e = 32'h8000_0000; t = 32'h7FFF_FFFF; end
            4: begin e = r; t = r + $urandom_range(0, 32'h000F_FFFF) - 32'h0008_0000; end
            default: begin e = $urandom; t = $urandom; end
        endcase
    endtask

    task automatic junk_inputs();
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.est      = $urandom;
        bus.target   = $urandom;
        bus.start    = 1'($urandom_range(0, 1));
    endtask

    // Feed one full measurement; stops after n_valid accepted samples (no result wait).
    task automatic feed(input int mode, input bit toggle_gaps, input int n_valid);
        logic [31:0] e, t;
        logic        v;
        bit          tog;
        int          cnt;
        int          guard;
        cnt   = 0;
        guard = 0;
        tog   = 1'b1;
        win_err.delete();
        while (cnt < n_valid && guard < 2000) begin
            v   = toggle_gaps ? tog : ($urandom_range(0, 3) != 0);
            tog = ~tog;
            gen(mode, cnt, e, t);
            bus.in_valid = v;
            bus.est      = e;
            bus.target   = t;
            bus.start    = ($urandom_range(0, 7) == 0);
            tick();
            if (v) begin
                if (cnt >= WASHOUT) win_err.push_back(longint'($signed(t)) - longint'($signed(e)));
                cnt++;
            end
            guard++;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        if (guard >= 2000) check("feed_budget", 64'(cnt), 64'(n_valid));
    endtask

    task automatic do_start();
        bus.start    = 1'b1;
        bus.in_valid = 1'($urandom_range(0, 1));
        tick();
        bus.start = 1'b0;
        check("start_busy", bus.busy, 1'b1);
        check("start_clears_sat", bus.sat, 1'b0);
    endtask

    task automatic run_measure(input int mode, input bit toggle_gaps, input int hold_cycles);
        logic [31:0] m0;
        logic [31:0] exp_m;
        logic        exp_s;
        int          wait_cnt;
        repeat ($urandom_range(1, 3)) begin
            junk_inputs();
            bus.start = 1'b0;
            tick();
            check("idle_busy", bus.busy, 1'b0);
        end
        do_start();
        feed(mode, toggle_gaps, WASHOUT + WIN);
        model_push();
        for (int i = 1; i <= 3; i++) begin
            junk_inputs();
            tick();
            if (i < 3) check("drain_valid_low", bus.mse_valid, 1'b0);
            else       check("latency_valid", bus.mse_valid, 1'b1);
            check("drain_busy", bus.busy, 1'b1);
        end
        wait_cnt = 0;
        while (!bus.mse_valid && wait_cnt < 20) begin
            tick();
            wait_cnt++;
        end
        if (!bus.mse_valid) begin
            check("result_timeout", bus.mse_valid, 1'b1);
            void'(exp_q.pop_front());
            void'(exp_sat_q.pop_front());
            return;
        end
        m0 = bus.mse;
        repeat (hold_cycles) begin
            junk_inputs();
            bus.mse_ready = 1'b0;
            tick();
            check("hold_valid", bus.mse_valid, 1'b1);
            check("hold_mse_stable", bus.mse, m0);
        end
        exp_m = exp_q.pop_front();
        exp_s = exp_sat_q.pop_front();
        check("mse", bus.mse, exp_m);
        check("sat", bus.sat, exp_s);
        bus.mse_ready = 1'b1;
        bus.start     = 1'b1;
        bus.in_valid  = 1'b0;
        tick();
        bus.mse_ready = 1'b0;
        bus.start     = 1'b0;
        check("post_busy", bus.busy, 1'b0);
        check("post_valid", bus.mse_valid, 1'b0);
        check("idle_sat_held", bus.sat, exp_s);
        check("idle_mse_held", bus.mse, exp_m);
    endtask

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.est       = '0;
        bus.target    = '0;
        bus.mse_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_valid", bus.mse_valid, 1'b0);
        check("rst_mse", bus.mse, 32'h0);
        check("rst_sat", bus.sat, 1'b0);

        run_measure(0, 1'b0, 2);
        run_measure(1, 1'b1, 10);
        run_measure(2, 1'b0, 3);
        run_measure(3, 1'b0, 1);
        run_measure(0, 1'b0, 0);
        for (int k = 0; k < 6; k++) run_measure(4 + (k % 2), 1'b0, $urandom_range(0, 5));

        // Reset in the middle of the window.
        do_start();
        feed(1, 1'b0, WASHOUT + 30);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_valid", bus.mse_valid, 1'b0);
        check("midrst_sat", bus.sat, 1'b0);
        check("midrst_mse", bus.mse, 32'h0);
        run_measure(1, 1'b1, 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
